// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: arbitrates load-use,
// taken-branch and data-memory wait disruptions and keeps saturating counters.
module pipeline_stall_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ID_EX_MemRead,
  input  logic [REG_ADDR_WIDTH-1:0] ID_EX_Rd,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_Rs1,
  input  logic [REG_ADDR_WIDTH-1:0] IF_ID_Rs2,
  input  logic                      branch_taken,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      PCWrite,
  output logic                      IF_ID_Write,
  output logic                      IF_ID_Flush,
  output logic                      ID_EX_Write,
  output logic                      ID_EX_Bubble,
  output logic                      EX_MEM_Write,
  output logic                      MEM_WB_Bubble,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      stall_cycles,
  output logic [CNT_WIDTH-1:0]      flush_count,
  output logic [1:0]                state_o
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    FAULT    = 2'd3
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic load_use;
  logic mem_busy;
  logic frozen;
  logic decode;
  logic flush_applied;
  logic stall_cycle;

  assign load_use = ID_EX_MemRead && (ID_EX_Rd != '0) &&
                    ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
  assign mem_busy = dmem_req && !dmem_ready;

  // Frozen cycles ignore branch/load-use; the held instructions are re-evaluated on release.
  assign frozen = (state == FAULT) ||
                  ((state == RUN) && mem_busy) ||
                  ((state == MEM_WAIT) && !dmem_ready);
  assign decode        = ((state == RUN) || (state == MEM_WAIT)) && !frozen;
  assign flush_applied = decode && branch_taken;
  assign stall_cycle   = ((state == RUN) || (state == MEM_WAIT)) && !PCWrite;
  assign state_o       = state;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Write   = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Write  = 1'b1;
    MEM_WB_Bubble = 1'b0;
    if (state == INIT) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      IF_ID_Flush   = 1'b1;
      ID_EX_Bubble  = 1'b1;
      MEM_WB_Bubble = 1'b1;
    end else if (frozen) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Write  = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (branch_taken) begin
      // Branch beats load-use: the ID instruction is discarded anyway.
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (load_use) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (state)
        INIT: state <= RUN;
        RUN: begin
          if (mem_busy) begin
            wait_cnt <= WAIT_W'(1);
            state    <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state <= RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= FAULT;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        FAULT: mem_timeout <= 1'b1;
        default: state <= INIT;
      endcase

      if (stall_cycle && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
      if (flush_applied && (flush_count != '1)) flush_count <= flush_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: table of single-cycle RUN vectors plus
// hand-written reset, memory-wait, timeout and saturation sequences.
module tb_pipeline_stall_ctrl;

  localparam int AW  = 5;
  localparam int MT  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble}
  localparam logic [6:0] O_NORMAL = 7'b1101010;
  localparam logic [6:0] O_FREEZE = 7'b0000001;
  localparam logic [6:0] O_LDUSE  = 7'b0001110;
  localparam logic [6:0] O_BRANCH = 7'b1111110;
  localparam logic [6:0] O_INIT   = 7'b0011111;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ID_EX_MemRead;
  logic [AW-1:0] ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2;
  logic          branch_taken, dmem_req, dmem_ready;
  logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Bubble;
  logic          EX_MEM_Write, MEM_WB_Bubble, mem_timeout;
  logic [CW-1:0] stall_cycles, flush_count;
  logic [1:0]    state_o;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  typedef struct {
    logic          memread;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          br;
    logic          req;
    logic          rdy;
    logic [6:0]    outs;
  } vec_t;

  vec_t vecs[10];

  pipeline_stall_ctrl #(
    .REG_ADDR_WIDTH(AW), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_Rd(ID_EX_Rd),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Write(ID_EX_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .EX_MEM_Write(EX_MEM_Write), .MEM_WB_Bubble(MEM_WB_Bubble),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles),
    .flush_count(flush_count), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input logic br, input logic req,
                       input logic rdy);
    ID_EX_MemRead = mr;
    ID_EX_Rd      = rd;
    IF_ID_Rs1     = rs1;
    IF_ID_Rs2     = rs2;
    branch_taken  = br;
    dmem_req      = req;
    dmem_ready    = rdy;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Check outputs mid-cycle, step the edge, then check counters against the bench model.
  task automatic run_cycle(input string name, input logic [6:0] outs, input logic [1:0] st);
    @(negedge clk);
    check({name, ".outs"}, {25'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                            ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble}, {25'd0, outs});
    check({name, ".state"}, {30'd0, state_o}, {30'd0, st});
    cyc();
    if ((st == 2'd1) || (st == 2'd2)) begin
      if (!outs[6] && exp_stall < SAT) exp_stall++;
      if (outs[4] && exp_flush < SAT) exp_flush++;
    end
    check({name, ".stall_cycles"}, {28'd0, stall_cycles}, exp_stall);
    check({name, ".flush_count"}, {28'd0, flush_count}, exp_flush);
  endtask

  initial begin
    vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORMAL};
    vecs[1] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, O_LDUSE};
    vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_NORMAL};
    vecs[3] = '{1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, 1'b0, O_LDUSE};
    vecs[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, O_NORMAL};
    vecs[5] = '{1'b1, 5'd5, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, O_NORMAL};
    vecs[6] = '{1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, O_BRANCH};
    vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, O_BRANCH};
    vecs[8] = '{1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, O_LDUSE};
    vecs[9] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, O_BRANCH};

    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.outs", {25'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                         ID_EX_Bubble, EX_MEM_Write, MEM_WB_Bubble}, {25'd0, O_INIT});
    check("reset.state", {30'd0, state_o}, 32'd0);
    check("reset.mem_timeout", {31'd0, mem_timeout}, 32'd0);
    check("reset.counters", {24'd0, stall_cycles, flush_count}, 32'd0);
    cyc();
    rst_n = 1'b1;
    run_cycle("release_init", O_INIT, 2'd0);
    run_cycle("release_run", O_NORMAL, 2'd1);

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].memread, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].br, vecs[i].req, vecs[i].rdy);
      run_cycle($sformatf("vec%0d", i), vecs[i].outs, 2'd1);
    end

    // Ready on the third wait cycle (last allowed for MEM_TIMEOUT=4) with a branch pending.
    drive(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    run_cycle("memwait0", O_FREEZE, 2'd1);
    run_cycle("memwait1", O_FREEZE, 2'd2);
    run_cycle("memwait2", O_FREEZE, 2'd2);
    dmem_ready = 1'b1;
    run_cycle("memwait_ready", O_BRANCH, 2'd2);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    run_cycle("memwait_back", O_NORMAL, 2'd1);
    check("memwait.mem_timeout", {31'd0, mem_timeout}, 32'd0);

    // Timeout: four freeze cycles, then sticky FAULT.
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
    run_cycle("timeout0", O_FREEZE, 2'd1);
    for (int i = 1; i < MT; i++) begin
      check($sformatf("timeout%0d.flag", i), {31'd0, mem_timeout}, 32'd0);
      run_cycle($sformatf("timeout%0d", i), O_FREEZE, 2'd2);
    end
    check("fault.flag", {31'd0, mem_timeout}, 32'd1);
    run_cycle("fault0", O_FREEZE, 2'd3);
    dmem_ready = 1'b1;
    run_cycle("fault_late_ready0", O_FREEZE, 2'd3);
    run_cycle("fault_late_ready1", O_FREEZE, 2'd3);
    check("fault.flag_held", {31'd0, mem_timeout}, 32'd1);

    rst_n = 1'b0;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    check("async_reset.state", {30'd0, state_o}, 32'd0);
    check("async_reset.flag", {31'd0, mem_timeout}, 32'd0);
    check("async_reset.counters", {24'd0, stall_cycles, flush_count}, 32'd0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cyc();
    rst_n = 1'b1;
    run_cycle("rerelease_init", O_INIT, 2'd0);

    // Saturation: continuous load-use drives stall_cycles to all-ones and holds it.
    drive(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) run_cycle($sformatf("sat%0d", i), O_LDUSE, 2'd1);
    check("sat.final", {28'd0, stall_cycles}, SAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
